// File: rtl/seq_shift_unit_pkg.sv
// Shared definitions for the iterative shifter: op encodings, FSM states and the
// single-bit step function also used by the combinational shifter.
package seq_shift_unit_pkg;

  localparam int unsigned MaxWidth = 64;

  typedef logic [2:0] sh_op_t;

  localparam sh_op_t SH_ROL  = 3'b000;
  localparam sh_op_t SH_ROR  = 3'b001;
  localparam sh_op_t SH_LSL  = 3'b010;
  localparam sh_op_t SH_LSR  = 3'b011;
  localparam sh_op_t SH_ASR  = 3'b100;
  localparam sh_op_t SH_PASS = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Operand lives in the low `width` bits of w; upper bits must be zero.
  // Returns {carry, w}; carry_in is passed through for the pass-through ops.
  function automatic logic [MaxWidth:0] step(input sh_op_t op,
                                             input logic [MaxWidth-1:0] w,
                                             input int unsigned width,
                                             input logic carry_in);
    logic [MaxWidth-1:0] mask;
    logic [MaxWidth-1:0] top;
    logic [MaxWidth-1:0] res;
    logic msb;
    logic lsb;
    logic cout;
    mask = {MaxWidth{1'b1}} >> (MaxWidth - width);
    top  = MaxWidth'(1) << (width - 1);
    msb  = |(w & top);
    lsb  = w[0];
    res  = w;
    cout = carry_in;
    case (op)
      SH_ROL: begin
        res  = ((w << 1) | (msb ? MaxWidth'(1) : '0)) & mask;
        cout = msb;
      end
      SH_ROR: begin
        res  = (w >> 1) | (lsb ? top : '0);
        cout = lsb;
      end
      SH_LSL: begin
        res  = (w << 1) & mask;
        cout = msb;
      end
      SH_LSR: begin
        res  = w >> 1;
        cout = lsb;
      end
      SH_ASR: begin
        res  = (w >> 1) | (msb ? top : '0);
        cout = lsb;
      end
      default: begin
        res  = w;
        cout = carry_in;
      end
    endcase
    return {cout, res};
  endfunction

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/response bundle between the control unit (master) and the shifter (slave).
interface seq_shift_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
);
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] data_in;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport master (
    output start, op, amt, data_in, carry_in,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, op, amt, data_in, carry_in,
    output busy, done, result, carry_out
  );
endinterface

// File: rtl/seq_shift_unit_shift_step.sv
// Combinational single-bit shift/rotate step with ARM-style carry out.
module shift_step
  import seq_shift_unit_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  sh_op_t           op_i,
  input  logic [Width-1:0] w_i,
  input  logic             c_i,
  output logic [Width-1:0] w_o,
  output logic             c_o
);

  logic [MaxWidth:0] r;

  assign r   = step(op_i, MaxWidth'(w_i), Width, c_i);
  assign w_o = r[Width-1:0];
  assign c_o = r[MaxWidth];

  if (Width < MaxWidth) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^r[MaxWidth-1:Width];
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate engine: one single-bit step per clock until the amount is
// exhausted, then a one-cycle done pulse with result and carry held until the next start.
module seq_shift_unit
  import seq_shift_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  seq_shift_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic             c_q, c_d;
  sh_op_t           op_q, op_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_w;
  logic             step_c;

  shift_step #(
    .Width(WIDTH)
  ) u_step (
    .op_i(op_q),
    .w_i (w_q),
    .c_i (c_q),
    .w_o (step_w),
    .c_o (step_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    c_d     = c_q;
    op_d    = op_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d  = bus.op;
          w_d   = bus.data_in;
          c_d   = bus.carry_in;
          cnt_d = bus.amt;
          if (bus.amt != '0) begin
            state_d = StShift;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StShift: begin
        w_d   = step_w;
        c_d   = step_c;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      w_q     <= '0;
      c_q     <= 1'b0;
      op_q    <= SH_ROL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      c_q     <= c_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  // busy decodes the registered state, so it never depends on start combinationally.
  assign bus.busy      = (state_q == StShift);
  assign bus.done      = done_q;
  assign bus.result    = w_q;
  assign bus.carry_out = c_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench: closed-form shift model with cycle-accurate timeline, directed
// cases from the block description and a randomized soak with occasional resets.
module tb_seq_shift_unit;

  localparam int unsigned W = 8;
  localparam int unsigned A = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  bit   chk_en;

  seq_shift_unit_if #(.WIDTH(W), .AMT_W(A)) bus ();

  seq_shift_unit #(
    .WIDTH(W),
    .AMT_W(A)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Closed-form result of n single-bit steps; returns {carry, result}.
  function automatic logic [8:0] model(input logic [2:0] o, input logic [7:0] w,
                                       input logic c, input int n);
    int   wi;
    int   s;
    int   r;
    int   k;
    logic co;
    wi = int'(w);
    if (n == 0 || o > 3'd4) return {c, w};
    k  = n % 8;
    r  = wi;
    co = c;
    case (o)
      3'd0: begin
        r  = ((wi << k) | (wi >> (8 - k))) & 255;
        co = (r & 1) != 0;
      end
      3'd1: begin
        r  = ((wi >> k) | (wi << (8 - k))) & 255;
        co = ((r >> 7) & 1) != 0;
      end
      3'd2: begin
        r  = (wi << n) & 255;
        co = (((wi << n) >> 8) & 1) != 0;
      end
      3'd3: begin
        r  = wi >> n;
        co = ((wi >> (n - 1)) & 1) != 0;
      end
      default: begin
        s  = w[7] ? wi - 256 : wi;
        r  = (s >>> n) & 255;
        co = ((s >>> (n - 1)) & 1) != 0;
      end
    endcase
    return {co, r[7:0]};
  endfunction

  // Timeline model: cycle of the accepting edge and the captured request.
  int         cyc;
  bit         m_valid;
  int         m_acc;
  int         m_n;
  logic [2:0] m_op;
  logic [7:0] m_w;
  logic       m_c;

  initial begin
    cyc     = 0;
    m_valid = 1'b0;
    m_acc   = 0;
    m_n     = 0;
    m_op    = '0;
    m_w     = '0;
    m_c     = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
    end else if ((!m_valid || (cyc - m_acc >= m_n + 2)) && bus.start) begin
      m_valid <= 1'b1;
      m_acc   <= cyc;
      m_n     <= int'(bus.amt);
      m_op    <= bus.op;
      m_w     <= bus.data_in;
      m_c     <= bus.carry_in;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int         j;
      logic       e_busy;
      logic       e_done;
      logic [8:0] e_rc;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_rc   = '0;
      if (m_valid) begin
        j = cyc - m_acc;
        if (j <= m_n) begin
          e_busy = 1'b1;
          e_rc   = model(m_op, m_w, m_c, j - 1);
        end else begin
          e_done = (j == m_n + 1);
          e_rc   = model(m_op, m_w, m_c, m_n);
        end
      end
      check("cyc busy", int'(bus.busy), int'(e_busy));
      check("cyc done", int'(bus.done), int'(e_done));
      check("cyc result", int'(bus.result), int'(e_rc[7:0]));
      check("cyc carry_out", int'(bus.carry_out), int'(e_rc[8]));
    end
  end

  task automatic run_op(input string name, input logic [2:0] o, input logic [7:0] d,
                        input logic ci, input logic [3:0] n,
                        input logic [7:0] er, input logic ec);
    int lat;
    int bc;
    bit seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.op       = o;
    bus.data_in  = d;
    bus.carry_in = ci;
    bus.amt      = n;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.op       = 3'($urandom);
    bus.data_in  = 8'($urandom);
    bus.carry_in = 1'($urandom);
    bus.amt      = 4'($urandom);
    lat  = 1;
    bc   = 0;
    seen = 1'b0;
    while (lat < 40) begin
      if (bus.busy) bc++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    check({name, " done seen"}, int'(seen), 1);
    check({name, " latency"}, lat, int'(n) + 1);
    check({name, " busy cycles"}, bc, int'(n));
    check({name, " result"}, int'(bus.result), int'(er));
    check({name, " carry_out"}, int'(bus.carry_out), int'(ec));
    @(negedge clk);
    check({name, " done one cycle"}, int'(bus.done), 0);
    check({name, " result held"}, int'(bus.result), int'(er));
  endtask

  initial begin
    logic [8:0] rc;
    int         dcount;
    logic [7:0] dres;
    logic       dcar;
    n_checks     = 0;
    n_fail       = 0;
    chk_en       = 1'b0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.op       = '0;
    bus.amt      = '0;
    bus.data_in  = '0;
    bus.carry_in = 1'b0;

    // Pin the model against hand-computed values.
    rc = model(3'd0, 8'h81, 1'b0, 1);  check("model rol", int'(rc), 9'h103);
    rc = model(3'd3, 8'h81, 1'b0, 3);  check("model lsr", int'(rc), 9'h010);
    rc = model(3'd4, 8'h80, 1'b0, 9);  check("model asr", int'(rc), 9'h1ff);
    rc = model(3'd2, 8'h01, 1'b0, 8);  check("model lsl8", int'(rc), 9'h100);
    rc = model(3'd2, 8'h01, 1'b1, 9);  check("model lsl9", int'(rc), 9'h000);
    rc = model(3'd1, 8'h01, 1'b1, 4);  check("model ror", int'(rc), 9'h010);
    rc = model(3'd1, 8'h01, 1'b0, 8);  check("model ror wrap", int'(rc), 9'h001);
    rc = model(3'd6, 8'h3c, 1'b1, 5);  check("model pass", int'(rc), 9'h13c);

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset result", int'(bus.result), 0);
    check("reset carry", int'(bus.carry_out), 0);
    rst = 1'b0;

    run_op("rol1", 3'd0, 8'h81, 1'b0, 4'd1, 8'h03, 1'b1);
    run_op("lsr3", 3'd3, 8'h81, 1'b1, 4'd3, 8'h10, 1'b0);
    run_op("asr9", 3'd4, 8'h80, 1'b0, 4'd9, 8'hff, 1'b1);
    run_op("lsl8", 3'd2, 8'h01, 1'b0, 4'd8, 8'h00, 1'b1);
    run_op("amt0", 3'd2, 8'h5a, 1'b1, 4'd0, 8'h5a, 1'b1);
    run_op("lsl15", 3'd2, 8'hff, 1'b1, 4'd15, 8'h00, 1'b0);
    run_op("pass", 3'd7, 8'ha5, 1'b0, 4'd3, 8'ha5, 1'b0);

    // Start while busy must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd1; bus.data_in = 8'h01; bus.carry_in = 1'b1; bus.amt = 4'd4;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.data_in = 8'hff; bus.amt = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    dcount = 0;
    dres   = '0;
    dcar   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) begin
        dcount++;
        dres = bus.result;
        dcar = bus.carry_out;
      end
      @(negedge clk);
    end
    check("ignore done count", dcount, 1);
    check("ignore result", int'(dres), 8'h10);
    check("ignore carry", int'(dcar), 0);

    // Reset in the second shift cycle aborts with no done.
    bus.start = 1'b1; bus.op = 3'd3; bus.data_in = 8'hf3; bus.carry_in = 1'b1; bus.amt = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    check("abort result", int'(bus.result), 0);
    check("abort carry", int'(bus.carry_out), 0);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) dcount++;
      @(negedge clk);
    end
    check("abort no done", dcount, 0);
    run_op("after abort", 3'd0, 8'h81, 1'b0, 4'd2, 8'h06, 1'b0);

    // Randomized soak; the per-cycle compare process checks against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.op       = 3'($urandom_range(0, 7));
      bus.data_in  = 8'($urandom);
      bus.carry_in = 1'($urandom);
      bus.amt      = 4'($urandom);
      rst          = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
# seq_shift_unit

Multi-cycle iterative shift/rotate engine for the multicycle ARM core datapath. The single-step combinational shifter moves an operand by exactly one bit. This block is its multi-step counterpart: it accepts an operand, a shift type and a shift amount, then applies one single-bit step per clock until the amount is exhausted. It returns the result and the ARM-style carry-out to the control unit over a start/done handshake.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥2)
- AMT_W, 4, shift-amount width; legal amounts 0..2^AMT_W−1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  3  shift type: 000 ROL, 001 ROR, 010 LSL, 011 LSR, 100 ASR, 101–111 pass-through
- amt  in  AMT_W  number of single-bit steps
- data_in  in  WIDTH  operand (signed for ASR)
- carry_in  in  1  current C flag
- busy  out  1  high while iterating
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  shifted operand
- carry_out  out  1  last bit shifted/rotated out; carry_in if no step performed

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE with start=1:
  - Capture op, data_in and carry_in into the working register and carry register.
  - Load the counter with amt.
  - Go to SHIFT if amt≠0, else to DONE.
- SHIFT: each cycle applies one step to the working register:
  - ROL: {w[W−2:0],w[W−1]}; carry←w[W−1]
  - ROR: {w[0],w[W−1:1]}; carry←w[0]
  - LSL: {w[W−2:0],0}; carry←w[W−1]
  - LSR: {0,w[W−1:1]}; carry←w[0]
  - ASR: {w[W−1],w[W−1:1]}; carry←w[0]
  - pass-through op: w unchanged; carry unchanged
  - The counter decrements each step. Leave for DONE on the step where counter==1.
- DONE: done=1 for exactly one cycle, then IDLE.
- result/carry_out reflect the working register and carry register at all times. They are held stable from done until the next accepted start.
- Amounts ≥WIDTH are iterated literally, with no clamping:
  - LSL/LSR → 0; carry=last bit out (0 once amt>WIDTH).
  - ASR → all sign bits; carry=sign.
  - Rotates wrap modulo WIDTH.
- start while busy or in DONE is ignored; there is no queueing.
- Inputs are only sampled on the accepting edge; later changes have no effect.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, carry_out=0, counter=0.
- Accept at edge t (IDLE, start=1):
  - amt=N>0: busy=1 during cycles t+1..t+N; done=1 in cycle t+N+1; busy=0 in that cycle.
  - amt=0: done=1 in cycle t+1; busy never asserts.
- Back-to-back: start may be asserted in the cycle done is high. It is not accepted until the following cycle (IDLE). Minimum issue interval is N+2 cycles.
- rst mid-operation: at the next edge all outputs return to reset values and the state goes to IDLE. There is no partial done.
- busy and done are registered, never combinational from start.

## Structure
- Shared package: op encodings (SH_ROL…SH_ASR, SH_PASS), state encoding, and a single-step function step(op, w) returning {carry, w}. The existing combinational shifter uses the same encodings.
- One sub-module is natural: shift_step (combinational, one-bit step + carry), instantiated once on the working register. The FSM, counter and registers live in seq_shift_unit.

## Test plan
- ROL, data_in=0x81, amt=1 → result=0x03, carry_out=1; done 2 cycles after start edge; busy high 1 cycle.
- LSR, data_in=0x81, amt=3 → result=0x10, carry_out=0; busy high exactly 3 cycles.
- ASR, data_in=0x80, amt=9 → result=0xFF, carry_out=1. Also LSL, data_in=0x01, amt=8 → result=0x00, carry_out=1.
- amt=0, op=LSL, data_in=0x5A, carry_in=1 → done at t+1, result=0x5A, carry_out=1, busy never high.
- Request ignored while busy: during ROR 0x01 by 4, pulse start with op=LSL, data_in=0xFF → final result=0x10, carry_out=0; only one done pulse.
- rst asserted in 2nd SHIFT cycle of LSR by 5 → next cycle busy=0, done=0, result=0x00. No done follows. A fresh start afterwards completes normally.
